// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, memory handshake, 2-entry queue and redirect
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic        IMemValid,
    input  logic [31:0] IMemData,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        Valid,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic [31:0] PCPlus4,
    output logic [5:0]  OpCode,
    output logic [5:0]  FuncCode,
    output logic [4:0]  BraCode,
    output logic        AddrErr
);

    // RUN: nothing outstanding; WAIT: outstanding data kept; DROP: outstanding data discarded
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] q0_instr_q, q0_instr_d;
    logic [31:0] q0_pc_q, q0_pc_d;
    logic [31:0] q1_instr_q, q1_instr_d;
    logic [31:0] q1_pc_q, q1_pc_d;
    logic [1:0]  count_q, count_d;
    logic        addr_err_q, addr_err_d;

    logic        accept;
    logic        enq;
    logic        deq;

    // Handshake and queue-control decode; Redirect suppresses issue, enqueue and dequeue
    always_comb begin
        IMemReq  = (state_q == ST_RUN) && (count_q < 2'd2) && !Redirect && !Reset;
        IMemAddr = fetch_pc_q;
        accept   = IMemReq && IMemReady;
        enq      = IMemValid && (state_q == ST_WAIT) && !Redirect;
        deq      = (count_q != 2'd0) && !Stall && !Redirect;
    end

    // Fetch control: PC advance on acceptance, outstanding-request tracking, redirect handling
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        addr_err_d = Redirect && (RedirectPC[1:0] != 2'b00);
        if (Redirect) begin
            fetch_pc_d = {RedirectPC[31:2], 2'b00};
            // A request still in flight must have its data thrown away when it arrives
            if ((state_q != ST_RUN) && !IMemValid) begin
                state_d = ST_DROP;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (accept) begin
                        state_d    = ST_WAIT;
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end
                ST_WAIT, ST_DROP: begin
                    if (IMemValid) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Two-entry queue kept as a shift pair so the head always sits in slot 0
    always_comb begin
        q0_instr_d = q0_instr_q;
        q0_pc_d    = q0_pc_q;
        q1_instr_d = q1_instr_q;
        q1_pc_d    = q1_pc_q;
        count_d    = count_q;
        if (Redirect) begin
            count_d = 2'd0;
        end else begin
            case ({enq, deq})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        q0_instr_d = IMemData;
                        q0_pc_d    = req_pc_q;
                    end else begin
                        q1_instr_d = IMemData;
                        q1_pc_d    = req_pc_q;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    q0_instr_d = q1_instr_q;
                    q0_pc_d    = q1_pc_q;
                    count_d    = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        q0_instr_d = IMemData;
                        q0_pc_d    = req_pc_q;
                    end else begin
                        q0_instr_d = q1_instr_q;
                        q0_pc_d    = q1_pc_q;
                        q1_instr_d = IMemData;
                        q1_pc_d    = req_pc_q;
                    end
                end
                default: count_d = count_q;
            endcase
        end
    end

    // State registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            q0_instr_q <= 32'd0;
            q0_pc_q    <= 32'd0;
            q1_instr_q <= 32'd0;
            q1_pc_q    <= 32'd0;
            count_q    <= 2'd0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            q0_instr_q <= q0_instr_d;
            q0_pc_q    <= q0_pc_d;
            q1_instr_q <= q1_instr_d;
            q1_pc_q    <= q1_pc_d;
            count_q    <= count_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Decoder-facing views of the queue head
    always_comb begin
        Valid    = (count_q != 2'd0);
        Instr    = q0_instr_q;
        InstrPC  = q0_pc_q;
        PCPlus4  = q0_pc_q + 32'd4;
        OpCode   = q0_instr_q[31:26];
        FuncCode = q0_instr_q[5:0];
        BraCode  = q0_instr_q[20:16];
        AddrErr  = addr_err_q;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        Clock;
    logic        Reset;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic        IMemValid;
    logic [31:0] IMemData;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        Valid;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic [31:0] PCPlus4;
    logic [5:0]  OpCode;
    logic [5:0]  FuncCode;
    logic [4:0]  BraCode;
    logic        AddrErr;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .Clock(Clock), .Reset(Reset),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady),
        .IMemValid(IMemValid), .IMemData(IMemData),
        .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .Valid(Valid), .Instr(Instr), .InstrPC(InstrPC), .PCPlus4(PCPlus4),
        .OpCode(OpCode), .FuncCode(FuncCode), .BraCode(BraCode), .AddrErr(AddrErr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int errors = 0;
    int checks = 0;

    // Reference state: next address memory should see, next PC decode should see
    logic [31:0] exp_fetch = 32'd0;
    logic [31:0] exp_pc    = 32'd0;
    logic        exp_aerr  = 1'b0;
    logic        mem_busy  = 1'b0;
    logic [31:0] mem_addr  = 32'd0;
    int          mem_wait  = 0;
    int          mem_lat   = 0;
    int          deliveries = 0;
    logic        last_acc  = 1'b0;
    logic [31:0] last_addr = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2001_0005;
            32'h0000_0004: return 32'h0022_1820;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    // One clock cycle: called at a falling edge, returns at the next falling edge
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
        logic        acc;
        logic [31:0] w;
        check("addr_err", 32'(AddrErr), 32'(exp_aerr));
        Stall      = st;
        Redirect   = rd;
        RedirectPC = rpc;
        IMemReady  = rdy;
        if (mem_busy && mem_wait == 0) begin
            IMemValid = 1'b1;
            IMemData  = memf(mem_addr);
        end else begin
            IMemValid = 1'b0;
            IMemData  = $urandom;
        end
        #1;
        check("one_outstanding", 32'(IMemReq & mem_busy), 32'd0);
        if (rd) check("req_during_redirect", 32'(IMemReq), 32'd0);
        if (Valid) begin
            w = memf(exp_pc);
            check("head_pc", InstrPC, exp_pc);
            check("head_instr", Instr, w);
            check("pc_plus4", PCPlus4, exp_pc + 32'd4);
            check("opcode", 32'(OpCode), 32'(w[31:26]));
            check("funccode", 32'(FuncCode), 32'(w[5:0]));
            check("bracode", 32'(BraCode), 32'(w[20:16]));
        end
        acc      = IMemReq && rdy;
        last_acc = acc;
        if (acc) begin
            check("fetch_addr", IMemAddr, exp_fetch);
            last_addr = IMemAddr;
        end
        if (Valid && !st && !rd) begin
            exp_pc = exp_pc + 32'd4;
            deliveries++;
        end
        if (IMemValid) mem_busy = 1'b0;
        else if (mem_busy) mem_wait--;
        if (acc) begin
            mem_busy  = 1'b1;
            mem_addr  = IMemAddr;
            mem_wait  = (mem_lat < 0) ? int'($urandom_range(0, 2)) : mem_lat;
            exp_fetch = exp_fetch + 32'd4;
        end
        if (rd) begin
            exp_fetch = {rpc[31:2], 2'b00};
            exp_pc    = exp_fetch;
        end
        exp_aerr = rd && (rpc[1:0] != 2'b00);
        @(negedge Clock);
    endtask

    task automatic wait_accept(input logic st);
        last_acc = 1'b0;
        for (int i = 0; i < 20 && !last_acc; i++) step(st, 1'b0, 32'd0, 1'b1);
        check("accept_timeout", 32'(last_acc), 32'd1);
    endtask

    // Clear redirect/stall so combinational request outputs can be inspected directly
    task automatic quiet_inputs();
        Redirect = 1'b0;
        Stall    = 1'b0;
        #1;
    endtask

    initial begin
        Reset = 1'b1; IMemReady = 1'b0; IMemValid = 1'b0; IMemData = 32'd0;
        Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'd0;
        repeat (2) @(negedge Clock);
        check("rst_req", 32'(IMemReq), 32'd0);
        check("rst_addr", IMemAddr, 32'd0);
        check("rst_valid", 32'(Valid), 32'd0);
        check("rst_instr", Instr, 32'd0);
        check("rst_instrpc", InstrPC, 32'd0);
        check("rst_addrerr", 32'(AddrErr), 32'd0);
        Reset = 1'b0;

        // First fetch latency with an always-ready, one-cycle memory
        mem_lat = 0;
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("first_accept", 32'(last_acc), 32'd1);
        check("valid_after_1", 32'(Valid), 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("valid_after_2", 32'(Valid), 32'd1);
        check("first_instr", Instr, 32'h2001_0005);
        check("first_opcode", 32'(OpCode), 32'h08);
        check("first_pc", InstrPC, 32'd0);
        check("first_pcplus4", PCPlus4, 32'd4);

        // Back-pressure fills the queue and stops issue
        repeat (6) step(1'b1, 1'b0, 32'd0, 1'b1);
        check("stall_req_off", 32'(IMemReq), 32'd0);
        check("stall_head_pc", InstrPC, 32'd0);
        repeat (12) step(1'b0, 1'b0, 32'd0, 1'b1);

        // Redirect while a request is outstanding; its data arrives next cycle and is dropped
        mem_lat = 1;
        wait_accept(1'b0);
        step(1'b0, 1'b1, 32'h0000_0100, 1'b1);
        check("drop_valid", 32'(Valid), 32'd0);
        repeat (8) step(1'b0, 1'b0, 32'd0, 1'b1);

        // Redirect in the same cycle as the data return, with Stall asserted
        mem_lat = 0;
        wait_accept(1'b1);
        step(1'b1, 1'b1, 32'h0000_0200, 1'b1);
        quiet_inputs();
        check("same_cycle_valid", 32'(Valid), 32'd0);
        check("same_cycle_req", 32'(IMemReq), 32'd1);
        check("same_cycle_addr", IMemAddr, 32'h0000_0200);

        // Memory not ready: request held, then replaced by a redirect
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0);
            check("hold_req", 32'(IMemReq), 32'd1);
            check("hold_addr", IMemAddr, 32'h0000_0200);
        end
        step(1'b0, 1'b1, 32'h0000_0300, 1'b0);
        quiet_inputs();
        check("replace_req", 32'(IMemReq), 32'd1);
        check("replace_addr", IMemAddr, 32'h0000_0300);

        // Misaligned redirect target
        step(1'b0, 1'b1, 32'h0000_0103, 1'b1);
        quiet_inputs();
        check("aerr_pulse", 32'(AddrErr), 32'd1);
        check("aerr_addr", IMemAddr, 32'h0000_0100);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("aerr_once", 32'(AddrErr), 32'd0);

        // PC wrap at the top of the address space
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        wait_accept(1'b0);
        check("wrap_first", last_addr, 32'hFFFF_FFFC);
        wait_accept(1'b0);
        check("wrap_next", last_addr, 32'h0000_0000);
        repeat (6) step(1'b0, 1'b0, 32'd0, 1'b1);

        // Randomized traffic against the reference stream
        mem_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            case ($urandom_range(0, 3))
                0:       rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: rpc = $urandom;
            endcase
            step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, rpc,
                 $urandom_range(0, 9) < 7);
        end
        repeat (10) step(1'b0, 1'b0, 32'd0, 1'b1);
        check("liveness", 32'(deliveries > 300), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
